// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the decode stage.
// The master side belongs to the fetch unit.
interface fetch_unit_if #(
   parameter int RAS_DEPTH = 8
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic             stall;
   logic             branch_taken;
   logic [15:0]      branch_target;
   logic [15:0]      instruction;
   logic [15:0]      address;
   logic             im_enable;
   logic [15:0]      ir_out;
   logic [15:0]      pc_out;
   logic             ir_valid;
   logic [CNT_W-1:0] ras_count;
   logic             stack_error;

   modport master (
      input  stall, branch_taken, branch_target, instruction,
      output address, im_enable, ir_out, pc_out, ir_valid, ras_count, stack_error
   );

   modport slave (
      output stall, branch_taken, branch_target, instruction,
      input  address, im_enable, ir_out, pc_out, ir_valid, ras_count, stack_error
   );
endinterface

// File: rtl/fetch_unit.sv
// PC and fetch stage. It pre-decodes JMP, CALL and RET against a return-address stack
// and accepts downstream branch redirects.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          RAS_DEPTH = 8
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master bus
);
   localparam int               PTR_W      = $clog2(RAS_DEPTH);
   localparam int               CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [15:0]      pc_r;
   logic [15:0]      ir_out_r;
   logic [15:0]      pc_out_r;
   logic             ir_valid_r;
   logic             stack_error_r;
   logic [CNT_W-1:0] ras_count_r;
   logic [15:0]      ras_mem_r [RAS_DEPTH];

   logic [3:0]       opcode_s;
   logic [15:0]      jump_target_s;
   logic [15:0]      pc_inc_s;
   logic [15:0]      ras_top_s;
   logic [15:0]      pc_next_s;
   logic [CNT_W-1:0] pop_index_s;
   logic             advance_s;
   logic             push_s;
   logic             pop_s;
   logic             halt_evt_s;
   logic             im_enable_s;

   // Pre-decode of the word on the memory bus: next PC, stack action, overflow/underflow
   always_comb begin
      opcode_s      = bus.instruction[15:12];
      jump_target_s = {4'h0, bus.instruction[11:0]};
      pc_inc_s      = pc_r + 16'd1;
      pop_index_s   = ras_count_r - CNT_W'(1);
      ras_top_s     = ras_mem_r[pop_index_s[PTR_W-1:0]];
      advance_s     = (state_r == ST_RUN) && !bus.branch_taken && !bus.stall;
      push_s        = 1'b0;
      pop_s         = 1'b0;
      halt_evt_s    = 1'b0;
      pc_next_s     = pc_inc_s;
      case (opcode_s)
         4'b1100: pc_next_s = jump_target_s;
         4'b1101: begin
            pc_next_s = jump_target_s;
            if (ras_count_r == FULL_COUNT) begin
               halt_evt_s = advance_s;
            end else begin
               push_s = advance_s;
            end
         end
         4'b1110: begin
            pc_next_s = ras_top_s;
            if (ras_count_r == {CNT_W{1'b0}}) begin
               halt_evt_s = advance_s;
            end else begin
               pop_s = advance_s;
            end
         end
         default: pc_next_s = pc_inc_s;
      endcase
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_START;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic. HALT is left only through reset.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_START: state_next_s = ST_RUN;
         ST_RUN: begin
            if (halt_evt_s) begin
               state_next_s = ST_HALT;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_HALT: state_next_s = ST_HALT;
         default: state_next_s = ST_START;
      endcase
   end

   // FSM outputs
   always_comb begin
      if (state_r == ST_RUN) begin
         im_enable_s = 1'b1;
      end else begin
         im_enable_s = 1'b0;
      end
   end

   // PC, fetch register and stack pointer. A redirect beats stall; a stack fault freezes the PC.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_r          <= RESET_PC;
         ir_out_r      <= 16'h0000;
         pc_out_r      <= 16'h0000;
         ir_valid_r    <= 1'b0;
         ras_count_r   <= {CNT_W{1'b0}};
         stack_error_r <= 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (bus.branch_taken) begin
                  pc_r       <= bus.branch_target;
                  ir_valid_r <= 1'b0;
               end else if (!bus.stall) begin
                  if (halt_evt_s) begin
                     ir_valid_r    <= 1'b0;
                     stack_error_r <= 1'b1;
                  end else begin
                     ir_out_r   <= bus.instruction;
                     pc_out_r   <= pc_r;
                     ir_valid_r <= 1'b1;
                     pc_r       <= pc_next_s;
                  end
                  if (push_s) begin
                     ras_count_r <= ras_count_r + CNT_W'(1);
                  end else if (pop_s) begin
                     ras_count_r <= pop_index_s;
                  end
               end
            end
            ST_HALT: begin
               ir_valid_r    <= 1'b0;
               stack_error_r <= 1'b1;
            end
            default: ir_valid_r <= 1'b0;
         endcase
      end
   end

   // Return-address stack storage. Its contents are meaningless after reset, so it has no reset.
   always_ff @(posedge clock) begin
      if (push_s) begin
         ras_mem_r[ras_count_r[PTR_W-1:0]] <= pc_inc_s;
      end
   end

   assign bus.address     = pc_r;
   assign bus.im_enable   = im_enable_s;
   assign bus.ir_out      = ir_out_r;
   assign bus.pc_out      = pc_out_r;
   assign bus.ir_valid    = ir_valid_r;
   assign bus.ras_count   = ras_count_r;
   assign bus.stack_error = stack_error_r;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. It covers directed scenarios plus a randomized run.
// The random run is scored against a queue-based architectural model.
module tb_fetch_unit;
   localparam int DEPTH_A = 8;
   localparam int DEPTH_B = 2;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ir;
      logic [3:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [15:0] tgt = 16'h0000;
   logic [15:0] mem [65536];

   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];
   logic [15:0] m_pc;
   logic [15:0] m_stack[$];
   bit          m_dead;
   bit          m_halt;

   fetch_unit_if #(.RAS_DEPTH(DEPTH_A)) bus_a ();
   fetch_unit_if #(.RAS_DEPTH(DEPTH_B)) bus_b ();

   fetch_unit #(.RESET_PC(16'h0000), .RAS_DEPTH(DEPTH_A)) dut_a (
      .clock(clk), .reset(reset), .bus(bus_a));
   fetch_unit #(.RESET_PC(16'hFFFF), .RAS_DEPTH(DEPTH_B)) dut_b (
      .clock(clk), .reset(reset), .bus(bus_b));

   assign bus_a.stall         = stall;
   assign bus_a.branch_taken  = br;
   assign bus_a.branch_target = tgt;
   assign bus_a.instruction   = mem[bus_a.address];
   assign bus_b.stall         = stall;
   assign bus_b.branch_taken  = br;
   assign bus_b.branch_target = tgt;
   assign bus_b.instruction   = mem[bus_b.address];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] plain_word();
      return {4'($urandom_range(0, 11)), 12'($urandom)};
   endfunction

   // Architectural model of dut_a for the upcoming edge
   task automatic model_step();
      logic [15:0] w;
      logic [15:0] npc;
      if (m_halt) return;
      if (m_dead) begin
         m_dead = 1'b0;
         return;
      end
      if (br) begin
         m_pc = tgt;
         return;
      end
      if (stall) return;
      w   = mem[m_pc];
      npc = m_pc + 16'd1;
      case (w[15:12])
         4'hC: npc = {4'h0, w[11:0]};
         4'hD: begin
            if (m_stack.size() == DEPTH_A) begin
               m_halt = 1'b1;
               return;
            end
            m_stack.push_back(m_pc + 16'd1);
            npc = {4'h0, w[11:0]};
         end
         4'hE: begin
            if (m_stack.size() == 0) begin
               m_halt = 1'b1;
               return;
            end
            npc = m_stack.pop_back();
         end
         default: ;
      endcase
      exp_q.push_back('{pc: m_pc, ir: w, cnt: 4'(m_stack.size())});
      m_pc = npc;
   endtask

   task automatic tick(input bit st, input bit b, input logic [15:0] t);
      if (!m_halt) check("addr_a", bus_a.address, m_pc);
      check("im_en_a", bus_a.im_enable, !m_halt && !m_dead);
      check("stkerr_a", bus_a.stack_error, m_halt);
      check("ras_a", bus_a.ras_count, m_stack.size());
      stall = st;
      br    = b;
      tgt   = t;
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0;
      br    = 1'b0;
      tgt   = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_pc  = 16'h0000;
      m_stack.delete();
      m_dead = 1'b1;
      m_halt = 1'b0;
      exp_q.delete();
   endtask

   // Scoreboard monitor: every newly presented valid fetch must match the oldest expectation
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus_a.ir_valid === 1'b1 && stall == 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: pc_out %h ir_out %h with no expected fetch",
                     bus_a.pc_out, bus_a.ir_out);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc", bus_a.pc_out, e.pc);
            check("sb_ir", bus_a.ir_out, e.ir);
            check("sb_ras", bus_a.ras_count, e.cnt);
         end
      end
   end

   initial begin
      logic [15:0] t2_addr [4];
      int          t2_cnt  [4];
      int          r;
      t2_addr = '{16'h0000, 16'h0001, 16'h0005, 16'h0002};
      t2_cnt  = '{0, 0, 1, 0};
      for (int i = 0; i < 65536; i++) mem[i] = plain_word();

      // Straight-line fetch; dut_b shows the FFFF -> 0000 wrap
      do_reset();
      check("t1_start_imen", bus_a.im_enable, 1'b0);
      check("t6_rst_addr_b", bus_b.address, 16'hFFFF);
      tick(1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         check("t1_addr", bus_a.address, k);
         if (k > 0) begin
            check("t1_ir", bus_a.ir_out, mem[k-1]);
            check("t1_pc_out", bus_a.pc_out, k - 1);
            check("t1_valid", bus_a.ir_valid, 1'b1);
         end
         if (k == 0) check("t6_addr_b_ffff", bus_b.address, 16'hFFFF);
         if (k == 1) check("t6_addr_b_wrap", bus_b.address, 16'h0000);
         tick(1'b0, 1'b0, 16'h0000);
      end

      // CALL 5 / RET with no bubbles
      mem[1] = 16'hD005;
      mem[5] = 16'hE000;
      do_reset();
      tick(1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         check("t2_addr", bus_a.address, t2_addr[k]);
         check("t2_ras", bus_a.ras_count, t2_cnt[k]);
         if (k > 0) check("t2_valid", bus_a.ir_valid, 1'b1);
         if (k == 2) check("t2_pc_out_call", bus_a.pc_out, 16'h0001);
         if (k == 3) check("t2_pc_out_ret", bus_a.pc_out, 16'h0005);
         tick(1'b0, 1'b0, 16'h0000);
      end
      mem[1] = plain_word();
      mem[5] = plain_word();

      // CALL at FFFF pushes the wrapped return address 0000
      mem[16'hFFFF] = 16'hD010;
      mem[16'h0010] = 16'hE000;
      do_reset();
      tick(1'b0, 1'b0, 16'h0000);
      check("t6_call_addr_b", bus_b.address, 16'hFFFF);
      tick(1'b0, 1'b0, 16'h0000);
      check("t6_tgt_addr_b", bus_b.address, 16'h0010);
      check("t6_ras_b_push", bus_b.ras_count, 2'd1);
      check("t6_pc_out_b", bus_b.pc_out, 16'hFFFF);
      tick(1'b0, 1'b0, 16'h0000);
      check("t6_ret_addr_b", bus_b.address, 16'h0000);
      check("t6_ras_b_pop", bus_b.ras_count, 2'd0);
      check("t6_valid_b", bus_b.ir_valid, 1'b1);

      // Three nested CALLs overflow the 2-entry stack of dut_b
      mem[16'h0010] = 16'hD020;
      mem[16'h0020] = 16'hD030;
      do_reset();
      tick(1'b0, 1'b0, 16'h0000);
      tick(1'b0, 1'b0, 16'h0000);
      check("t3_addr1_b", bus_b.address, 16'h0010);
      tick(1'b0, 1'b0, 16'h0000);
      check("t3_addr2_b", bus_b.address, 16'h0020);
      check("t3_ras2_b", bus_b.ras_count, 2'd2);
      tick(1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         check("t3_imen_b", bus_b.im_enable, 1'b0);
         check("t3_valid_b", bus_b.ir_valid, 1'b0);
         check("t3_stkerr_b", bus_b.stack_error, 1'b1);
         check("t3_ras_b", bus_b.ras_count, 2'd2);
         tick(1'b0, 1'b0, 16'h0000);
      end
      do_reset();
      check("t3_rst_stkerr_b", bus_b.stack_error, 1'b0);
      check("t3_rst_addr_b", bus_b.address, 16'hFFFF);
      mem[16'hFFFF] = plain_word();
      mem[16'h0010] = plain_word();
      mem[16'h0020] = plain_word();

      // RET with an empty stack halts at once
      mem[0] = 16'hE000;
      do_reset();
      tick(1'b0, 1'b0, 16'h0000);
      tick(1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 2; k++) begin
         check("t4_imen", bus_a.im_enable, 1'b0);
         check("t4_stkerr", bus_a.stack_error, 1'b1);
         check("t4_valid", bus_a.ir_valid, 1'b0);
         tick(1'b0, 1'b0, 16'h0000);
      end
      do_reset();
      check("t4_rst_stkerr", bus_a.stack_error, 1'b0);
      check("t4_rst_addr", bus_a.address, 16'h0000);
      mem[0] = plain_word();

      // Stall at pc 4, then a redirect during stall overrides the CALL on the bus
      mem[4] = 16'hD100;
      do_reset();
      for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 16'h0000);
         check("t5_stall_addr", bus_a.address, 16'h0004);
         check("t5_stall_ir", bus_a.ir_out, mem[3]);
      end
      tick(1'b1, 1'b1, 16'h0020);
      check("t5_br_addr", bus_a.address, 16'h0020);
      check("t5_br_valid", bus_a.ir_valid, 1'b0);
      check("t5_br_ras", bus_a.ras_count, 4'd0);
      tick(1'b0, 1'b0, 16'h0000);
      check("t5_refetch_addr", bus_a.address, 16'h0021);
      check("t5_refetch_valid", bus_a.ir_valid, 1'b1);
      check("t5_refetch_pc_out", bus_a.pc_out, 16'h0020);

      // Randomized program with stalls, redirects and resets
      for (int i = 0; i < 4096; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       mem[i] = {4'hC, 12'($urandom_range(0, 255))};
            1:       mem[i] = {4'hD, 12'($urandom_range(0, 255))};
            2:       mem[i] = 16'hE000;
            default: mem[i] = plain_word();
         endcase
      end
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                 16'($urandom_range(0, 255)));
         end
      end
      check("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
